// File: rtl/io_pkg.sv
// Shared types for the front-panel I/O conditioning blocks.
package io_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE,
        S_HIGH,
        S_FALL
    } state_t;

endpackage

// File: rtl/switch_debouncer_if.sv
// Board-side pins and conditioned outputs of the switch debouncer.
interface switch_debouncer_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 btn_raw;
    logic [BUS_WIDTH-1:0] sw_raw;
    logic                 ready_in;
    logic [BUS_WIDTH-1:0] data_in;
    logic                 bounce;

    modport master (
        output btn_raw, sw_raw,
        input  ready_in, data_in, bounce
    );

    modport slave (
        input  btn_raw, sw_raw,
        output ready_in, data_in, bounce
    );
endinterface

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, any width.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/switch_debouncer.sv
// Debounces the ready push-button and latches the data switches when a
// press is confirmed.
module switch_debouncer
    import io_pkg::*;
#(
    parameter int BUS_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debouncer_if.slave  io
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                 btn_s;
    logic [BUS_WIDTH-1:0] sw_s;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk(clk), .rst_n(rst_n), .d(io.btn_raw), .q(btn_s)
    );

    sync_2ff #(.WIDTH(BUS_WIDTH)) u_sync_sw (
        .clk(clk), .rst_n(rst_n), .d(io.sw_raw), .q(sw_s)
    );

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 load_data, bounce_nxt;
    logic                 ready_q, bounce_q;
    logic [BUS_WIDTH-1:0] data_q;

    // ready_in gets its own flop from the next state so the output never
    // sees a multi-bit state decode glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_LOW;
            cnt      <= '0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            bounce_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_q  <= (state_nxt == S_HIGH) || (state_nxt == S_FALL);
            bounce_q <= bounce_nxt;
            if (load_data) data_q <= sw_s;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_data  = 1'b0;
        bounce_nxt = 1'b0;
        case (state)
            S_LOW: begin
                if (btn_s) begin
                    state_nxt = S_RISE;
                    cnt_nxt   = '0;
                end
            end
            S_RISE: begin
                if (!btn_s) begin
                    state_nxt  = S_LOW;
                    cnt_nxt    = '0;
                    bounce_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    load_data = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_nxt = S_FALL;
                    cnt_nxt   = '0;
                end
            end
            S_FALL: begin
                if (btn_s) begin
                    state_nxt  = S_HIGH;
                    cnt_nxt    = '0;
                    bounce_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign io.ready_in = ready_q;
    assign io.data_in  = data_q;
    assign io.bounce   = bounce_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a run-length reference model.
module tb_switch_debouncer;
    localparam int BW = 8;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst_n;

    switch_debouncer_if #(.BUS_WIDTH(BW)) io ();

    switch_debouncer #(.BUS_WIDTH(BW), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .io(io.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the debounced level flips once the synchronised button has
    // disagreed with it for DC+1 consecutive samples; any shorter run of
    // disagreement that ends is one bounce.
    logic          s1, s2;
    logic [BW-1:0] w1, w2;
    logic          m_ready, m_bounce;
    logic [BW-1:0] m_data;
    int            run;

    always @(posedge clk) begin
        if (!rst_n) begin
            s1 = 0; s2 = 0; w1 = '0; w2 = '0;
            m_ready = 0; m_bounce = 0; m_data = '0; run = 0;
        end else begin
            m_bounce = 0;
            if (s2 != m_ready) begin
                run++;
                if (run == DC + 1) begin
                    m_ready = s2;
                    if (s2) m_data = w2;
                    run = 0;
                end
            end else begin
                if (run > 0) m_bounce = 1;
                run = 0;
            end
            s2 = s1; s1 = io.btn_raw;
            w2 = w1; w1 = io.sw_raw;
        end
    end

    int   bounces = 0;
    int   rises   = 0;
    logic prev_ready = 1'b0;
    bit   cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready_in", int'(io.ready_in), int'(m_ready));
            chk("data_in",  int'(io.data_in),  int'(m_data));
            chk("bounce",   int'(io.bounce),   int'(m_bounce));
        end
        if (io.bounce === 1'b1) bounces++;
        if (io.ready_in === 1'b1 && prev_ready === 1'b0) rises++;
        prev_ready = io.ready_in;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        io.btn_raw = 1'b0;
        io.sw_raw  = '0;
        tick(3);
        cmp_en = 1'b1;
        chk("rst_ready", int'(io.ready_in), 0);
        chk("rst_data",  int'(io.data_in), 0);
        chk("rst_bounce", int'(io.bounce), 0);
        rst_n = 1'b1;
        tick(3);

        // clean press
        io.sw_raw = 8'hA5;
        tick(3);
        bounces = 0;
        io.btn_raw = 1'b1;
        tick(6);
        chk("clean_not_yet", int'(io.ready_in), 0);
        tick(1);
        chk("clean_ready", int'(io.ready_in), 1);
        chk("clean_data", int'(io.data_in), 'hA5);
        chk("model_ready", int'(m_ready), 1);
        chk("clean_no_bounce", bounces, 0);

        // switches move while held
        io.sw_raw = 8'h3C;
        tick(8);
        chk("held_data", int'(io.data_in), 'hA5);

        // release with one re-press glitch
        bounces = 0;
        rises = 0;
        io.btn_raw = 1'b0;
        tick(2);
        io.btn_raw = 1'b1;
        tick(1);
        io.btn_raw = 1'b0;
        tick(6);
        chk("rel_still_high", int'(io.ready_in), 1);
        tick(1);
        chk("rel_low", int'(io.ready_in), 0);
        chk("rel_bounces", bounces, 1);
        chk("rel_no_rise", rises, 0);
        tick(4);

        // next press captures new switch word
        io.btn_raw = 1'b1;
        tick(7);
        chk("press2_ready", int'(io.ready_in), 1);
        chk("press2_data", int'(io.data_in), 'h3C);
        tick(3);

        // reset mid-press, button still held
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_ready", int'(io.ready_in), 0);
        chk("mid_rst_data", int'(io.data_in), 0);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_not_yet", int'(io.ready_in), 0);
        tick(1);
        chk("post_rst_ready", int'(io.ready_in), 1);
        chk("post_rst_data", int'(io.data_in), 'h3C);

        // bouncy press seen by a downstream rising-edge detector
        io.btn_raw = 1'b0;
        tick(12);
        bounces = 0;
        rises = 0;
        io.sw_raw = 8'h5A;
        io.btn_raw = 1'b1;
        tick(2);
        io.btn_raw = 1'b0;
        tick(1);
        io.btn_raw = 1'b1;
        tick(6);
        chk("bp_not_yet", int'(io.ready_in), 0);
        tick(1);
        chk("bp_ready", int'(io.ready_in), 1);
        chk("bp_data", int'(io.data_in), 'h5A);
        tick(6);
        chk("bp_bounces", bounces, 1);
        chk("bp_one_rise", rises, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
